// File: rtl/mem_arbiter_pkg.sv
// Shared types for the instruction/data memory arbiter: transfer sizes,
// arbiter FSM states and the alignment rule.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    WORD     = 2'd0,
    HALFWORD = 2'd1,
    BYTE     = 2'd2
  } tsize_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Only the two low address bits matter for natural alignment.
  function automatic logic is_aligned(input logic [1:0] addr, input tsize_e size);
    case (size)
      WORD:     return addr == 2'b00;
      HALFWORD: return !addr[0];
      default:  return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto a single memory port.
// One transaction in flight; data has priority, bounded by a starvation limit.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  tsize_e            d_size,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_write_data,
  output tsize_e            mem_tsize,
  input  logic [DATA_W-1:0] mem_data
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_q;
  logic              owner_i_q;
  logic              we_q;
  logic              err_q;
  logic              grant_ok;
  logic              i_first;
  logic [DATA_W-1:0] resp_data;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and grant; grants only when no access is in progress
  always_comb begin
    state_d  = state_q;
    i_gnt    = 1'b0;
    d_gnt    = 1'b0;
    grant_ok = !rst && (state_q == IDLE || state_q == RESP);
    i_first  = i_req && (starve_q == CNT_MAX || !d_req);
    case (state_q)
      IDLE, RESP: begin
        if (grant_ok && i_first)     i_gnt = 1'b1;
        else if (grant_ok && d_req)  d_gnt = 1'b1;
        state_d = (i_gnt || d_gnt) ? ACCESS : IDLE;
      end
      ACCESS:  state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Writes and misaligned accesses return zero data
  assign resp_data = (we_q || err_q) ? '0 : mem_data;

  // Latch the granted request onto the memory port for exactly the ACCESS
  // cycle, then capture the response for the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      mem_tsize      <= WORD;
      i_rvalid       <= 1'b0;
      i_rdata        <= '0;
      i_err          <= 1'b0;
      d_rvalid       <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;
      owner_i_q      <= 1'b0;
      we_q           <= 1'b0;
      err_q          <= 1'b0;
      starve_q       <= '0;
    end else begin
      mem_address    <= '0;
      mem_write      <= 1'b0;
      mem_write_data <= '0;
      mem_tsize      <= WORD;
      i_rvalid       <= 1'b0;
      i_rdata        <= '0;
      i_err          <= 1'b0;
      d_rvalid       <= 1'b0;
      d_rdata        <= '0;
      d_err          <= 1'b0;

      if (i_gnt) begin
        mem_address <= i_addr;
        owner_i_q   <= 1'b1;
        we_q        <= 1'b0;
        err_q       <= !is_aligned(i_addr[1:0], WORD);
      end else if (d_gnt) begin
        mem_address    <= d_addr;
        mem_tsize      <= d_size;
        mem_write_data <= d_wdata;
        mem_write      <= d_we && is_aligned(d_addr[1:0], d_size);
        owner_i_q      <= 1'b0;
        we_q           <= d_we;
        err_q          <= !is_aligned(d_addr[1:0], d_size);
      end

      if (state_q == ACCESS) begin
        if (owner_i_q) begin
          i_rvalid <= 1'b1;
          i_rdata  <= resp_data;
          i_err    <= err_q;
        end else begin
          d_rvalid <= 1'b1;
          d_rdata  <= resp_data;
          d_err    <= err_q;
        end
      end

      // Counts data wins over a waiting fetch; saturates at the limit
      if (!i_req || i_gnt)                        starve_q <= '0;
      else if (d_gnt && starve_q != CNT_MAX)      starve_q <= starve_q + CNT_W'(1);
    end
  end

endmodule
